// File: rtl/instr_issue_buffer_pkg.sv
// rtl/instr_issue_buffer_pkg.sv - shared widths, opcodes and field positions for the issue buffer
package instr_issue_buffer_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/instr_issue_buffer_hazard_check.sv
// rtl/instr_issue_buffer_hazard_check.sv - decides whether head+1 may issue alongside the head
module ib_hazard_check
    import instr_issue_buffer_pkg::*;
(
    input  logic [INSTR_W-1:0] instr_a,
    input  logic [INSTR_W-1:0] instr_b,
    output logic               hazard
);

    logic [5:0] op_a;
    logic [5:0] op_b;
    logic [5:0] funct_a;
    logic [4:0] rs_b;
    logic [4:0] rt_b;
    logic [4:0] dest_a;
    logic       ctrl_a;
    logic       mem_a;
    logic       mem_b;
    logic       raw;
    logic       unused_bits;

    assign op_a    = instr_a[OP_MSB:OP_LSB];
    assign op_b    = instr_b[OP_MSB:OP_LSB];
    assign funct_a = instr_a[FUNCT_MSB:FUNCT_LSB];
    assign rs_b    = instr_b[RS_MSB:RS_LSB];
    assign rt_b    = instr_b[RT_MSB:RT_LSB];

    assign unused_bits = ^{instr_a[RS_MSB:RS_LSB], instr_a[10:6], instr_b[15:0]};

    always_comb begin
        dest_a = 5'd0;
        case (op_a)
            OP_RTYPE: if (funct_a != FUNCT_JR) dest_a = instr_a[RD_MSB:RD_LSB];
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_ANDI,
            OP_ORI, OP_LUI, OP_LW:  dest_a = instr_a[RT_MSB:RT_LSB];
            OP_JAL:   dest_a = REG_RA;
            default:  dest_a = 5'd0;
        endcase
    end

    assign ctrl_a = (op_a == OP_J) || (op_a == OP_JAL) || (op_a == OP_BEQ) || (op_a == OP_BNE)
                 || ((op_a == OP_RTYPE) && (funct_a == FUNCT_JR));
    assign mem_a  = (op_a == OP_LW) || (op_a == OP_SW);
    assign mem_b  = (op_b == OP_LW) || (op_b == OP_SW);
    // Writes to $0 are discarded, so they never create a dependency.
    assign raw    = (dest_a != 5'd0) && ((dest_a == rs_b) || (dest_a == rt_b));

    assign hazard = ctrl_a || (mem_a && mem_b) || raw;

endmodule

// File: rtl/instr_issue_buffer.sv
// rtl/instr_issue_buffer.sv - dual-slot in-order instruction buffer between fetch and decode
module instr_issue_buffer
    import instr_issue_buffer_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int IWIDTH   = INSTR_W,
    parameter int PC_WIDTH = PC_W
) (
    input  logic                       ib_i_clk,
    input  logic                       ib_i_rst,
    input  logic                       ib_i_flush,
    input  logic                       ib_i_valid_1,
    input  logic                       ib_i_valid_2,
    input  logic [IWIDTH-1:0]          ib_i_instr_1,
    input  logic [IWIDTH-1:0]          ib_i_instr_2,
    input  logic [PC_WIDTH-1:0]        ib_i_pc_1,
    input  logic [PC_WIDTH-1:0]        ib_i_pc_2,
    output logic                       ib_o_ready,
    input  logic                       ib_i_stall,
    output logic                       ib_o_valid_1,
    output logic                       ib_o_valid_2,
    output logic [IWIDTH-1:0]          ib_o_instr_1,
    output logic [IWIDTH-1:0]          ib_o_instr_2,
    output logic [PC_WIDTH-1:0]        ib_o_pc_1,
    output logic [PC_WIDTH-1:0]        ib_o_pc_2,
    output logic                       ib_o_split,
    output logic [$clog2(DEPTH):0]     ib_o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IWIDTH-1:0]   instr_mem [DEPTH];
    logic [PC_WIDTH-1:0] pc_mem    [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr_b;
    logic [PW-1:0] wr_ptr_b;
    logic [CW-1:0] count;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic          push_ok;
    logic          hazard;

    assign rd_ptr_b   = rd_ptr + 1'b1;
    assign wr_ptr_b   = wr_ptr + 1'b1;
    assign ib_o_ready = (count <= CW'(DEPTH - 2));
    assign ib_o_count = count;
    assign push_ok    = ib_o_ready && !ib_i_flush;
    assign push_n     = push_ok ? ({1'b0, ib_i_valid_1} + {1'b0, ib_i_valid_2}) : 2'd0;

    ib_hazard_check u_hazard (
        .instr_a (instr_mem[rd_ptr]),
        .instr_b (instr_mem[rd_ptr_b]),
        .hazard  (hazard)
    );

    // Issue decisions look only at entries already stored, so a push is never bypassed.
    always_comb begin
        pop_n = 2'd0;
        if (!ib_i_stall) begin
            if (count == CW'(1))
                pop_n = 2'd1;
            else if (count >= CW'(2))
                pop_n = hazard ? 2'd1 : 2'd2;
        end
    end

    always_ff @(posedge ib_i_clk) begin
        if (push_ok) begin
            if (ib_i_valid_1) begin
                instr_mem[wr_ptr] <= ib_i_instr_1;
                pc_mem[wr_ptr]    <= ib_i_pc_1;
                if (ib_i_valid_2) begin
                    instr_mem[wr_ptr_b] <= ib_i_instr_2;
                    pc_mem[wr_ptr_b]    <= ib_i_pc_2;
                end
            end else if (ib_i_valid_2) begin
                instr_mem[wr_ptr] <= ib_i_instr_2;
                pc_mem[wr_ptr]    <= ib_i_pc_2;
            end
        end
    end

    always_ff @(posedge ib_i_clk or negedge ib_i_rst) begin
        if (!ib_i_rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            ib_o_valid_1 <= 1'b0;
            ib_o_valid_2 <= 1'b0;
            ib_o_instr_1 <= '0;
            ib_o_instr_2 <= '0;
            ib_o_pc_1    <= '0;
            ib_o_pc_2    <= '0;
            ib_o_split   <= 1'b0;
        end else if (ib_i_flush) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            ib_o_valid_1 <= 1'b0;
            ib_o_valid_2 <= 1'b0;
            ib_o_split   <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push_n);
            rd_ptr <= rd_ptr + PW'(pop_n);
            count  <= count + CW'(push_n) - CW'(pop_n);
            if (!ib_i_stall) begin
                ib_o_valid_1 <= (pop_n != 2'd0);
                ib_o_valid_2 <= (pop_n == 2'd2);
                ib_o_split   <= (count >= CW'(2)) && (pop_n == 2'd1);
                if (pop_n != 2'd0) begin
                    ib_o_instr_1 <= instr_mem[rd_ptr];
                    ib_o_pc_1    <= pc_mem[rd_ptr];
                end
                if (pop_n == 2'd2) begin
                    ib_o_instr_2 <= instr_mem[rd_ptr_b];
                    ib_o_pc_2    <= pc_mem[rd_ptr_b];
                end
            end
        end
    end

endmodule
